msx_status_writer: RTL and testbench
====================================

// Module: msx_status_writer
// PURPOSE
//  Return path of the OSD status word: pushes core-detected cart info (mapper, SRAM size) back into
//  hps_io via status_out/status_set so the OSD shows what auto-detection chose. Sits beside
//  msx_config: msx_config reads status, this block writes it. Writes only dedicated read-only info
//  fields; never touches user-selected fields, so msx_config's reload compare is unaffected.
// PARAMETERS
//  ECHO_TIMEOUT  4096  cycles to wait for HPS_status to echo a written field before a retry
//  MAX_RETRY     3     write attempts per update before err is set and the update is dropped
// PORTS
//  clk                 in   1        system clock
//  reset_n             in   1        asynchronous, active-low reset
//  HPS_status          in   64       current status word from hps_io
//  detect_valid        in   2        1-cycle pulse per slot [0]=A [1]=B: detection result valid
//  mapper_detected     in   6 x2     detected mapper_typ_t per slot
//  sram_size_detected  in   3 x2     detected SRAM size code per slot (only [0] used)
//  status_out          out  64       word for hps_io status_in
//  status_set          out  1        1-cycle write strobe to hps_io
//  busy                out  1        high in any state other than IDLE
//  err                 out  1        sticky: an update exhausted MAX_RETRY; cleared by reset only
// BEHAVIOUR
//  Info fields (package constants): DET_MAPPER_A [45:40], DET_MAPPER_B [51:46], DET_SRAM_A [54:52].
//  Reset: status_out=0, status_set=0, busy=0, err=0, pending flags clear, FSM=IDLE, counters=0.
//  Capture: detect_valid[i] latches value into pend_val[i] and sets pend[i]; a later pulse
//   overwrites pend_val[i] (latest wins), also while that slot's write is in flight; the in-flight
//   write completes with its old value, then the slot is re-queued.
//  FSM: IDLE -> LOAD when any pend; A has priority when both pending (same-cycle pulses: A then B).
//   LOAD (1 cyc): clear pend[i]; if pend_val equals field in HPS_status -> IDLE, no write
//    (dropped, not counted). Else status_out = HPS_status with only slot i fields replaced.
//   SET (1 cyc): status_set=1; status_out held stable from LOAD through end of WAIT.
//   WAIT: each cycle compare field(s) in HPS_status to written value; match -> IDLE, retry=0.
//    Timer reaching ECHO_TIMEOUT-1 -> retry++ ; retry<MAX_RETRY -> LOAD (re-merge fresh
//    HPS_status), else err=1, retry=0 -> IDLE.
//  Latency: pulse at cycle t (idle FSM) -> status_set high at t+3 (capture, LOAD, SET).
//  Width: mapper field stores mapper_typ_t[5:0] verbatim; SRAM field 3 bits verbatim.
//  Reset_n asserted mid-write: status_set drops immediately, pending updates lost.
// CONFIGURATION
//  MSX_STATUS_SRAM_EN defined: slot A write also merges sram_size_detected[0] into DET_SRAM_A
//   and the echo check requires both fields to match.
//  Not defined: DET_SRAM_A never written, bits [54:52] passed through from HPS_status unchanged,
//   sram_size_detected ignored.
// STRUCTURE
//  Shared MSX package: info field LSB/MSB constants, writer FSM state enum, status word typedef.
//  One sub-module: msx_status_field_merge (combinational: base word, slot, values -> merged
//   word plus echo-match flag); FSM, timer, retry and pending registers live in this block.
// TESTING
//  1 Reset, HPS_status=0, pulse detect_valid=2'b01, mapper=6'd5 -> status_set 1 cycle at t+3,
//    status_out[45:40]=5, all other bits 0; echo at +10 -> busy low next cycle, err=0.
//  2 Same-cycle pulses A=3, B=7 -> two strobes, A first; B write status_out keeps [45:40]=3 echoed.
//  3 Detected value already in HPS_status -> no status_set, busy high exactly 1 cycle (LOAD).
//  4 Never echo, ECHO_TIMEOUT=16 -> 3 strobes 18 cycles apart, then err=1, busy=0.
//  5 New A pulse (value 9) during WAIT of value 4 -> echo 4, then second strobe with 9.
//  6 reset_n low during WAIT -> status_set/busy/status_out 0 asynchronously; no strobe after.
//  Build both with/without MSX_STATUS_SRAM_EN: sram=3'd4 -> [54:52]=4 only when defined.

Source files
------------

// File: rtl/msx_status_writer_pkg.sv
// Shared MSX definitions for the status write-back path: info-field bit
// positions in the 64-bit OSD status word, the writer FSM state type and
// the status word typedefs.
package msx_status_writer_pkg;

  typedef logic [63:0] status_word_t;
  typedef logic [5:0]  mapper_typ_t;
  typedef logic [2:0]  sram_size_t;

  // Read-only info fields owned by the writer; user-selected fields are never touched.
  localparam int DET_MAPPER_A_LSB = 40;
  localparam int DET_MAPPER_A_MSB = 45;
  localparam int DET_MAPPER_B_LSB = 46;
  localparam int DET_MAPPER_B_MSB = 51;
  localparam int DET_SRAM_A_LSB   = 52;
  localparam int DET_SRAM_A_MSB   = 54;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SET  = 2'd2,
    ST_WAIT = 2'd3
  } wr_state_t;

endpackage

// File: rtl/msx_status_writer_if.sv
// Status return path between cart detection, the writer and hps_io.
// Handshake: detect_valid[i] is a 1-cycle pulse qualifying mapper/sram for
// slot i (no back-pressure, latest pulse wins). status_set is a 1-cycle
// strobe; status_out is stable from the strobe until the writer sees the
// written field(s) echoed back on HPS_status or gives up.
interface msx_status_writer_if;
  import msx_status_writer_pkg::*;

  status_word_t    HPS_status;
  logic [1:0]      detect_valid;
  mapper_typ_t [1:0] mapper_detected;
  sram_size_t  [1:0] sram_size_detected;
  status_word_t    status_out;
  logic            status_set;

  modport master (
    input  HPS_status, detect_valid, mapper_detected, sram_size_detected,
    output status_out, status_set
  );

  modport slave (
    output HPS_status, detect_valid, mapper_detected, sram_size_detected,
    input  status_out, status_set
  );

endinterface

// File: rtl/msx_status_field_merge.sv
// Combinational field merge: replaces the selected slot's info field(s) in
// a base status word and reports whether the base already holds them.
// MSX_STATUS_SRAM_EN: slot A also carries the SRAM size field.
module msx_status_field_merge
  import msx_status_writer_pkg::*;
(
  input  status_word_t base,
  input  logic         slot,
  input  mapper_typ_t  mapper,
`ifdef MSX_STATUS_SRAM_EN
  input  sram_size_t   sram,
`endif
  output status_word_t merged,
  output logic         match
);

  // Splice the slot's fields into the base word and compare them in place.
  always_comb begin
    merged = base;
    match  = 1'b0;
    if (!slot) begin
      merged[DET_MAPPER_A_MSB:DET_MAPPER_A_LSB] = mapper;
      match = (base[DET_MAPPER_A_MSB:DET_MAPPER_A_LSB] == mapper);
`ifdef MSX_STATUS_SRAM_EN
      merged[DET_SRAM_A_MSB:DET_SRAM_A_LSB] = sram;
      match = match && (base[DET_SRAM_A_MSB:DET_SRAM_A_LSB] == sram);
`endif
    end else begin
      merged[DET_MAPPER_B_MSB:DET_MAPPER_B_LSB] = mapper;
      match = (base[DET_MAPPER_B_MSB:DET_MAPPER_B_LSB] == mapper);
    end
  end

endmodule

// File: rtl/msx_status_writer.sv
// Writes auto-detected cart info (mapper per slot, slot-A SRAM size) back
// into the hps_io status word so the OSD shows it, then waits for the echo
// and retries on timeout. Optional macro: MSX_STATUS_SRAM_EN (also write
// the slot-A SRAM size field; otherwise bits [54:52] pass through).
module msx_status_writer
  import msx_status_writer_pkg::*;
#(
  parameter int ECHO_TIMEOUT = 4096,
  parameter int MAX_RETRY    = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  msx_status_writer_if.master bus,
  output logic                busy,
  output logic                err,
  output wr_state_t           state_dbg
);

  localparam int TW = (ECHO_TIMEOUT > 2) ? $clog2(ECHO_TIMEOUT) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  wr_state_t         state;
  logic [1:0]        pend;
  mapper_typ_t [1:0] pend_map;
  logic              wr_slot;
  mapper_typ_t       wr_map;
  logic [TW-1:0]     timer;
  logic [RW-1:0]     retry;
`ifdef MSX_STATUS_SRAM_EN
  sram_size_t        pend_sram;
  sram_size_t        wr_sram;
  sram_size_t        cur_sram;
`endif

  logic         first_load;
  mapper_typ_t  cur_map;
  status_word_t merged;
  logic         match;

  // A fresh update takes the pending value; retries and the echo wait reuse the in-flight value.
  assign first_load = (state == ST_LOAD) && (retry == '0);
  assign cur_map    = first_load ? pend_map[wr_slot] : wr_map;
`ifdef MSX_STATUS_SRAM_EN
  assign cur_sram   = first_load ? pend_sram : wr_sram;
`endif

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  msx_status_field_merge u_merge (
    .base   (bus.HPS_status),
    .slot   (wr_slot),
    .mapper (cur_map),
`ifdef MSX_STATUS_SRAM_EN
    .sram   (cur_sram),
`endif
    .merged (merged),
    .match  (match)
  );

  // Writer FSM with echo timer, retry count and per-slot pending capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      pend           <= '0;
      pend_map       <= '0;
      wr_slot        <= 1'b0;
      wr_map         <= '0;
      timer          <= '0;
      retry          <= '0;
      err            <= 1'b0;
      bus.status_out <= '0;
      bus.status_set <= 1'b0;
`ifdef MSX_STATUS_SRAM_EN
      pend_sram      <= '0;
      wr_sram        <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (pend[0]) begin
            wr_slot <= 1'b0;
            state   <= ST_LOAD;
          end else if (pend[1]) begin
            wr_slot <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (first_load) pend[wr_slot] <= 1'b0;
          wr_map <= cur_map;
`ifdef MSX_STATUS_SRAM_EN
          wr_sram <= cur_sram;
`endif
          if (match) begin
            retry <= '0;
            state <= ST_IDLE;
          end else begin
            bus.status_out <= merged;
            bus.status_set <= 1'b1;
            state          <= ST_SET;
          end
        end
        ST_SET: begin
          bus.status_set <= 1'b0;
          timer          <= '0;
          state          <= ST_WAIT;
        end
        ST_WAIT: begin
          if (match) begin
            retry <= '0;
            state <= ST_IDLE;
          end else if (timer == TW'(ECHO_TIMEOUT - 1)) begin
            if (int'(retry) + 1 < MAX_RETRY) begin
              retry <= retry + 1'b1;
              state <= ST_LOAD;
            end else begin
              err   <= 1'b1;
              retry <= '0;
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Capture last so a pulse coinciding with LOAD re-queues the slot with the new value.
      for (int i = 0; i < 2; i++) begin
        if (bus.detect_valid[i]) begin
          pend[i]     <= 1'b1;
          pend_map[i] <= bus.mapper_detected[i];
        end
      end
`ifdef MSX_STATUS_SRAM_EN
      if (bus.detect_valid[0]) pend_sram <= bus.sram_size_detected[0];
`endif
    end
  end

endmodule

// File: tb/tb_msx_status_writer.sv
// Bench for msx_status_writer (ECHO_TIMEOUT=16, MAX_RETRY=3). Expected
// status words come from a field-splicing model built from the info field
// positions; honours MSX_STATUS_SRAM_EN the same way the design does.
module tb_msx_status_writer;
  import msx_status_writer_pkg::*;

  logic      clk = 1'b0;
  logic      reset_n;
  logic      busy;
  logic      err;
  wr_state_t state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;
  logic [63:0] exp_q[$];

  msx_status_writer_if bus();

  msx_status_writer #(.ECHO_TIMEOUT(16), .MAX_RETRY(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .busy      (busy),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // Clock and strobe counter.
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.status_set === 1'b1) strobe_cnt++;

  // Reference model: word written for a slot = base with that slot's fields replaced.
  function automatic logic [63:0] model_write(logic [63:0] base, int slot, logic [5:0] m, logic [2:0] s);
    logic [63:0] w;
    w = base;
    if (slot == 0) begin
      w = (w & ~(64'h3F << 40)) | ({58'd0, m} << 40);
`ifdef MSX_STATUS_SRAM_EN
      w = (w & ~(64'h7 << 52)) | ({61'd0, s} << 52);
`endif
    end else begin
      w = (w & ~(64'h3F << 46)) | ({58'd0, m} << 46);
    end
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic [1:0] dv, input logic [5:0] ma, input logic [5:0] mb, input logic [2:0] sa);
    @(posedge clk); #1;
    bus.detect_valid          = dv;
    bus.mapper_detected[0]    = ma;
    bus.mapper_detected[1]    = mb;
    bus.sram_size_detected[0] = sa;
    bus.sram_size_detected[1] = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
    bus.detect_valid = 2'b00;
  endtask

  task automatic set_hps(input logic [63:0] v);
    @(posedge clk); #1;
    bus.HPS_status = v;
  endtask

  task automatic wait_strobe(input int max, output int n, output bit hit);
    n = 0;
    hit = 1'b0;
    while (n < max && !hit) begin
      @(negedge clk);
      n++;
      if (bus.status_set === 1'b1) hit = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    if (bus.status_out !== 64'd0) begin n_bad++; $display("FAIL reset_status_out: got %0h want 0", bus.status_out); end
    n_cmp++;
    if (bus.status_set !== 1'b0) begin n_bad++; $display("FAIL reset_status_set: got %b want 0", bus.status_set); end
    n_cmp++;
    idle_cycles(3);
    #2 reset_n = 1'b1;
    idle_cycles(2);
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++;
  endtask

  task automatic test_single();
    logic [5:0] m;
    logic [2:0] s;
    logic [63:0] e;
    int n;
    bit hit;
    m = 6'($urandom_range(1, 63));
    s = 3'($urandom_range(0, 7));
    bus.HPS_status = 64'd0;
    exp_q.push_back(model_write(64'd0, 0, m, s));
    pulse(2'b01, m, 6'd0, s);
    wait_strobe(10, n, hit);
    if (n != 3) begin n_bad++; $display("FAIL t1_latency: got %0d cycles want 3", n); end
    n_cmp++;
    e = exp_q.pop_front();
    if (bus.status_out !== e) begin n_bad++; $display("FAIL t1_word: got %0h want %0h", bus.status_out, e); end
    n_cmp++;
    @(negedge clk);
    if (bus.status_set !== 1'b0) begin n_bad++; $display("FAIL t1_strobe_width: got %b want 0", bus.status_set); end
    n_cmp++;
    idle_cycles(5);
    if (bus.status_out !== e || busy !== 1'b1) begin
      n_bad++; $display("FAIL t1_hold: got out=%0h busy=%b want out=%0h busy=1", bus.status_out, busy, e);
    end
    n_cmp++;
    set_hps(e);
    @(negedge clk);
    if (busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy_before_echo: got %b want 1", busy); end
    n_cmp++;
    @(negedge clk);
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL t1_after_echo: got busy=%b err=%b want 0 0", busy, err);
    end
    n_cmp++;
  endtask

  task automatic test_same_cycle();
    logic [63:0] base, ea, eb;
    logic [5:0] a, b;
    logic [2:0] s;
    int n;
    bit hit;
    base = {$urandom, $urandom};
    a = base[45:40] ^ 6'($urandom_range(1, 63));
    b = base[51:46] ^ 6'($urandom_range(1, 63));
    s = 3'($urandom_range(0, 7));
    bus.HPS_status = base;
    ea = model_write(base, 0, a, s);
    eb = model_write(ea, 1, b, 3'd0);
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    pulse(2'b11, a, b, s);
    wait_strobe(10, n, hit);
    if (n != 3) begin n_bad++; $display("FAIL t2_a_latency: got %0d want 3", n); end
    n_cmp++;
    ea = exp_q.pop_front();
    if (bus.status_out !== ea) begin n_bad++; $display("FAIL t2_a_word: got %0h want %0h", bus.status_out, ea); end
    n_cmp++;
    idle_cycles(2);
    set_hps(ea);
    wait_strobe(10, n, hit);
    if (!hit) begin n_bad++; $display("FAIL t2_b_strobe: got none want one"); end
    n_cmp++;
    eb = exp_q.pop_front();
    if (bus.status_out !== eb) begin n_bad++; $display("FAIL t2_b_word: got %0h want %0h", bus.status_out, eb); end
    n_cmp++;
    if (bus.status_out[45:40] !== a) begin n_bad++; $display("FAIL t2_b_keeps_a: got %0d want %0d", bus.status_out[45:40], a); end
    n_cmp++;
    set_hps(eb);
    idle_cycles(3);
    if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL t2_idle: got busy=%b err=%b want 0 0", busy, err); end
    n_cmp++;
  endtask

  task automatic test_already_present();
    logic [63:0] base;
    int bc, s0;
    base = {$urandom, $urandom};
    bus.HPS_status = base;
    for (int slot = 1; slot >= 0; slot--) begin
      s0 = strobe_cnt;
      bc = 0;
      if (slot == 1) pulse(2'b10, 6'd0, base[51:46], 3'd0);
      else           pulse(2'b01, base[45:40], 6'd0, base[54:52]);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (busy === 1'b1) bc++;
      end
      if (bc != 1) begin n_bad++; $display("FAIL t3_busy_cycles_slot%0d: got %0d want 1", slot, bc); end
      n_cmp++;
      if (strobe_cnt != s0) begin n_bad++; $display("FAIL t3_no_strobe_slot%0d: got %0d want 0", slot, strobe_cnt - s0); end
      n_cmp++;
    end
  endtask

  task automatic test_new_pulse_in_wait();
    logic [63:0] base, e1, e2;
    logic [5:0] v1, v2;
    logic [2:0] s1, s2;
    int n;
    bit hit;
    base = {$urandom, $urandom};
    v1 = base[45:40] ^ 6'($urandom_range(1, 63));
    v2 = v1 ^ 6'($urandom_range(1, 63));
    s1 = 3'($urandom_range(0, 7));
    s2 = 3'($urandom_range(0, 7));
    bus.HPS_status = base;
    e1 = model_write(base, 0, v1, s1);
    e2 = model_write(e1, 0, v2, s2);
    pulse(2'b01, v1, 6'd0, s1);
    wait_strobe(10, n, hit);
    if (bus.status_out !== e1) begin n_bad++; $display("FAIL t5_first_word: got %0h want %0h", bus.status_out, e1); end
    n_cmp++;
    pulse(2'b01, v2, 6'd0, s2);
    idle_cycles(1);
    if (bus.status_out !== e1) begin n_bad++; $display("FAIL t5_inflight_held: got %0h want %0h", bus.status_out, e1); end
    n_cmp++;
    set_hps(e1);
    wait_strobe(12, n, hit);
    if (!hit) begin n_bad++; $display("FAIL t5_second_strobe: got none want one"); end
    n_cmp++;
    if (bus.status_out !== e2) begin n_bad++; $display("FAIL t5_second_word: got %0h want %0h", bus.status_out, e2); end
    n_cmp++;
    set_hps(e2);
    idle_cycles(3);
    if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL t5_idle: got busy=%b err=%b want 0 0", busy, err); end
    n_cmp++;
  endtask

  task automatic test_timeout();
    logic [63:0] hps, e;
    logic [5:0] v;
    logic [2:0] s;
    int t[$];
    hps = {$urandom, $urandom};
    v = hps[45:40] ^ 6'($urandom_range(1, 63));
    s = 3'($urandom_range(0, 7));
    bus.HPS_status = hps;
    pulse(2'b01, v, 6'd0, s);
    for (int c = 0; c < 75; c++) begin
      @(negedge clk);
      if (bus.status_set === 1'b1) begin
        t.push_back(c);
        e = model_write(hps, 0, v, s);
        if (bus.status_out !== e) begin n_bad++; $display("FAIL t4_word%0d: got %0h want %0h", t.size(), bus.status_out, e); end
        n_cmp++;
        hps = {$urandom, $urandom};
        hps[45:40] = ~v;
        bus.HPS_status = hps;
      end
    end
    if (t.size() != 3) begin n_bad++; $display("FAIL t4_strobe_count: got %0d want 3", t.size()); end
    n_cmp++;
    if (t.size() == 3) begin
      if (t[1] - t[0] != 18 || t[2] - t[1] != 18) begin
        n_bad++; $display("FAIL t4_spacing: got %0d,%0d want 18,18", t[1] - t[0], t[2] - t[1]);
      end
      n_cmp++;
    end
    if (err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL t4_err: got err=%b busy=%b want 1 0", err, busy); end
    n_cmp++;
  endtask

  task automatic test_reset_mid_write();
    logic [63:0] base;
    logic [5:0] v, w;
    int n, s0;
    bit hit;
    base = {$urandom, $urandom};
    v = base[45:40] ^ 6'($urandom_range(1, 63));
    w = base[51:46] ^ 6'($urandom_range(1, 63));
    bus.HPS_status = base;
    pulse(2'b01, v, 6'd0, 3'd1);
    wait_strobe(10, n, hit);
    pulse(2'b10, 6'd0, w, 3'd0);
    #2 reset_n = 1'b0;
    #1;
    if (bus.status_set !== 1'b0 || busy !== 1'b0 || bus.status_out !== 64'd0) begin
      n_bad++; $display("FAIL t6_async_clear: got set=%b busy=%b out=%0h want 0 0 0", bus.status_set, busy, bus.status_out);
    end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL t6_err_cleared: got %b want 0", err); end
    n_cmp++;
    idle_cycles(2);
    #2 reset_n = 1'b1;
    s0 = strobe_cnt;
    idle_cycles(30);
    if (strobe_cnt != s0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL t6_no_strobe_after: got strobes=%0d busy=%b want 0 0", strobe_cnt - s0, busy);
    end
    n_cmp++;
  endtask

  // Watchdog: any hang still ends the run with a report.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Sequencer and final report.
  initial begin
    bus.HPS_status         = 64'd0;
    bus.detect_valid       = 2'b00;
    bus.mapper_detected    = '0;
    bus.sram_size_detected = '0;
    test_reset();
    test_single();
    test_same_cycle();
    test_already_present();
    test_new_pulse_in_wait();
    test_timeout();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
